shr_dout_capture: RTL and testbench
===================================

SHR_DOUT_CAPTURE -- requirements
Module: shr_dout_capture

Interface
REQ-001 Parameter N_BITS, default 491: number of bits read back from the shift-register chain.
REQ-002 Parameter HALF, default 4: clk_in cycles per shr_clk phase; legal range is 2 or more.
REQ-003 Reset is asynchronous and active-low; the block has one clock.
REQ-004 clk_in  input  1  system clock, PLL output.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level; a readback is requested when start is sampled high in IDLE.
REQ-007 abort  input  1  level; returns the block to IDLE from any state.
REQ-008 dout  input  1  serial data from the chain, asynchronous to clk_in.
REQ-009 shr_clk  output  1  shift clock to the chain.
REQ-010 shr_syn  output  1  capture/sync strobe to the chain.
REQ-011 busy  output  1  high in SYNC and SHIFT.
REQ-012 done  output  1  one-cycle pulse when a readback completes.
REQ-013 bit_cnt  output  clog2(N_BITS+1)  number of bits captured in the current readback.
REQ-014 data_reg  output  N_BITS  captured chain contents.

Function
REQ-015 The block has a 3-flop FSM with states IDLE, SYNC, SHIFT and DONE.
REQ-016 IDLE to SYNC: start=1 and abort=0 sampled at cycle 0 puts the block in SYNC at cycle 1.
- start in any other state is ignored.
REQ-017 shr_clk period is 2*HALF cycles.
- Each period begins with HALF low cycles, then HALF high cycles.
- The divider counter restarts at 0 on entry to SYNC.
REQ-018 SYNC lasts exactly one shr_clk period with shr_syn=1 throughout, giving one shr_clk pulse that latches the chain.
REQ-019 SHIFT lasts N_BITS shr_clk periods with shr_syn=0.
REQ-020 Sampling in SHIFT:
- synchronized dout is sampled on the last high-phase cycle of each period;
- data_reg shifts left: data_reg <= {data_reg[N_BITS-2:0], dout_s};
- bit_cnt increments on each sample.
REQ-021 The first bit received ends in data_reg[N_BITS-1] (MSB-first).
REQ-022 After the N_BITS-th sample the block enters DONE for one cycle.
- In DONE, done=1, shr_clk=0 and busy=0; the block then returns to IDLE.
- The done pulse lands at cycle 1+2*HALF*(N_BITS+1) after the start sample.
REQ-023 data_reg and bit_cnt hold their values in IDLE and DONE.
- Both are cleared to 0 on entry to SYNC.
REQ-024 dout passes through a two-flop synchronizer, giving 2 cycles of latency.
- dout must be stable at least 3 cycles before the sample cycle.
REQ-025 abort=1 takes precedence over start and every transition.
- The next state is IDLE, shr_clk=0, shr_syn=0, and done is not pulsed.
- data_reg and bit_cnt keep their partial contents.
REQ-026 shr_clk and shr_syn are driven from flops (glitch-free); shr_clk is 0 in IDLE and DONE.
REQ-027 bit_cnt never exceeds N_BITS.

Reset
REQ-028 rst_n=0 forces the following, immediately and regardless of clk_in:
- state IDLE;
- shr_clk=0, shr_syn=0, busy=0, done=0;
- bit_cnt=0, data_reg=0;
- divider counter and synchronizer flops cleared to 0.
REQ-029 Reset asserted mid-readback abandons the readback; no done pulse follows release.
REQ-030 The first start is accepted on the first clk_in edge after rst_n deasserts.

Structure
REQ-031 Package shr_pkg holds the FSM state typedef, the default N_BITS=491 and the default HALF=4.
REQ-032 The synchronizer is one sub-module, shr_sync2, with ports clk_in, rst_n, d and q.
REQ-033 The FSM, divider, shift register and bit counter stay in shr_dout_capture.

Verification (N_BITS=8, HALF=2 unless stated)
REQ-034 Basic readback:
- stimulus: start pulse; dout driven with pattern 8'hA5, MSB first, updated at each shr_clk falling edge;
- required: data_reg=8'hA5, bit_cnt=8, done high exactly at cycle 37 after the start sample, shr_syn high for cycles 1-4.
REQ-035 Early abort:
- stimulus: abort asserted at cycle 15;
- required: state IDLE at cycle 16, shr_clk=0, no done pulse, bit_cnt=2.
REQ-036 Start while busy:
- stimulus: start held high for the whole transfer;
- required: one done at cycle 37, then a second readback begins at cycle 38 (SYNC at 39).
REQ-037 Reset mid-shift:
- stimulus: rst_n=0 at cycle 20 for 3 cycles;
- required: all outputs 0 during reset, then idle with no done pulse.
REQ-038 Full-width readback:
- stimulus: N_BITS=491, HALF=4, alternating 1/0 pattern;
- required: data_reg[490]=1, data_reg[0]=1, bit_cnt=491, done at cycle 1+8*492=3937.
REQ-039 Simultaneous start and abort in IDLE:
- required: the block stays in IDLE, busy=0 and shr_syn=0.

Source files
------------

// File: rtl/shr_pkg.sv
// Shared types and default sizing for the shift-register readback block.
package shr_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3
  } shr_state_t;

  localparam int N_BITS_DEF = 491;
  localparam int HALF_DEF   = 4;

endpackage

// File: rtl/shr_sync2.sv
// Two-flop synchronizer for the chain's serial data, which is asynchronous to clk_in.
module shr_sync2 (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/shr_dout_capture.sv
// Shift-register chain readback: one sync pulse to latch the chain, then N_BITS
// shift clocks capturing dout MSB-first into data_reg.
//
// state   | meaning
// S_IDLE  | waiting for start, shr_clk low
// S_SYNC  | one shr_clk period with shr_syn high, latches the chain
// S_SHIFT | N_BITS shr_clk periods, dout sampled at end of each high phase
// S_DONE  | one-cycle done pulse, then back to idle
module shr_dout_capture
  import shr_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int HALF   = HALF_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        dout,
  output logic                        shr_clk,
  output logic                        shr_syn,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_BITS+1)-1:0] bit_cnt,
  output logic [N_BITS-1:0]           data_reg
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam int DW = $clog2(2 * HALF);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * HALF - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

  shr_state_t    state;
  logic [DW-1:0] div;
  logic [DW-1:0] div_inc;
  logic          dout_s;

  assign div_inc = div + DW'(1);

  shr_sync2 u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (dout),
    .q      (dout_s)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div      <= '0;
      shr_clk  <= 1'b0;
      shr_syn  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= '0;
      data_reg <= '0;
    end else if (abort) begin
      // partial capture is kept for debug; only the sequencing is dropped
      state   <= S_IDLE;
      div     <= '0;
      shr_clk <= 1'b0;
      shr_syn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_SYNC;
            div      <= '0;
            shr_clk  <= 1'b0;
            shr_syn  <= 1'b1;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            data_reg <= '0;
          end
        end
        S_SYNC: begin
          if (div == DIV_LAST) begin
            state   <= S_SHIFT;
            div     <= '0;
            shr_clk <= 1'b0;
            shr_syn <= 1'b0;
          end else begin
            div     <= div_inc;
            shr_clk <= (div_inc >= DIV_HALF);
          end
        end
        S_SHIFT: begin
          if (div == DIV_LAST) begin
            data_reg <= {data_reg[N_BITS-2:0], dout_s};
            bit_cnt  <= bit_cnt + CW'(1);
            div      <= '0;
            shr_clk  <= 1'b0;
            if (bit_cnt == CNT_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            div     <= div_inc;
            shr_clk <= (div_inc >= DIV_HALF);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          shr_clk <= 1'b0;
          shr_syn <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shr_dout_capture.sv
// Self-checking bench for shr_dout_capture: small instance (N=8, HALF=2) and full-width instance.
module tb_shr_dout_capture;

  localparam int N  = 8;
  localparam int H  = 2;
  localparam int NB = 491;
  localparam int HB = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic start  = 1'b0;
  logic abort  = 1'b0;
  logic dout   = 1'b0;
  logic shr_clk, shr_syn, busy, done;
  logic [3:0] bit_cnt;
  logic [7:0] data_reg;

  logic start_b = 1'b0;
  logic abort_b = 1'b0;
  logic dout_b  = 1'b0;
  logic shr_clk_b, shr_syn_b, busy_b, done_b;
  logic [8:0]    bit_cnt_b;
  logic [NB-1:0] data_reg_b;

  shr_dout_capture #(.N_BITS(N), .HALF(H)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .dout(dout),
    .shr_clk(shr_clk), .shr_syn(shr_syn), .busy(busy), .done(done),
    .bit_cnt(bit_cnt), .data_reg(data_reg)
  );

  shr_dout_capture #(.N_BITS(NB), .HALF(HB)) u_big (
    .clk_in(clk_in), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dout(dout_b),
    .shr_clk(shr_clk_b), .shr_syn(shr_syn_b), .busy(busy_b), .done(done_b),
    .bit_cnt(bit_cnt_b), .data_reg(data_reg_b)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // chain model: falling edge j of shr_clk presents bit j-1 of the pattern, MSB first
  logic [7:0] pat;
  int fcnt   = 0;
  int fcnt_b = 0;

  always @(negedge shr_clk) begin
    fcnt++;
    if (fcnt >= 1 && fcnt <= N) dout = pat[N-fcnt];
  end

  always @(negedge shr_clk_b) begin
    fcnt_b++;
    dout_b = ((fcnt_b - 1) % 2 == 0);
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // one readback with optional abort driven during cycle ab (0 = none)
  task automatic run_xfer(input logic [7:0] p, input int ab, output logic [7:0] d,
                          output int c, output int dc, output int shape_err);
    bit live;
    pat = p;
    fcnt = 0;
    dc = -1;
    shape_err = 0;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    for (int i = 0; i < 46; i++) begin
      live = (ab == 0 || cyc <= ab) && cyc <= 2*H*(N+1);
      if (busy !== live) shape_err++;
      if (shr_syn !== (live && cyc <= 2*H)) shape_err++;
      if (shr_clk !== (live && ((cyc - 1) % (2*H)) >= H)) shape_err++;
      if (done === 1'b1) begin
        if (dc < 0) dc = cyc;
        else shape_err++;
      end
      if (cyc == ab) abort = 1'b1;
      step();
      abort = 1'b0;
    end
    d = data_reg;
    c = int'(bit_cnt);
  endtask

  typedef struct {
    logic [7:0] pat;
    int         ab;
    logic [7:0] exp_data;
    int         exp_cnt;
    int         exp_done;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] got_d, rp, ed;
  int got_c, got_dc, serr, rab, ec, found;
  logic [NB-1:0] exp_big;

  initial begin
    tbl[0] = '{8'hA5, 0,  8'hA5, 8, 37};
    tbl[1] = '{8'hA5, 15, 8'h02, 2, -1};
    tbl[2] = '{8'h3C, 30, 8'h0F, 6, -1};
    tbl[3] = '{8'hFF, 0,  8'hFF, 8, 37};
    tbl[4] = '{8'h01, 36, 8'h00, 7, -1};
    tbl[5] = '{8'hC3, 9,  8'h01, 1, -1};

    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {shr_clk, shr_syn, busy, done, bit_cnt, data_reg}, '0);
    check("reset_big", {shr_clk_b, shr_syn_b, busy_b, done_b, bit_cnt_b, data_reg_b}, '0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    #1;

    // first start right after release, then the vector table
    for (int t = 0; t < 6; t++) begin
      run_xfer(tbl[t].pat, tbl[t].ab, got_d, got_c, got_dc, serr);
      check($sformatf("tbl%0d_data", t), got_d, tbl[t].exp_data);
      check($sformatf("tbl%0d_cnt", t), got_c, tbl[t].exp_cnt);
      check($sformatf("tbl%0d_done_cycle", t), got_dc, tbl[t].exp_done);
      check($sformatf("tbl%0d_waveform_errs", t), serr, 0);
    end

    // randomized readbacks against an arithmetic model
    for (int r = 0; r < 20; r++) begin
      rp  = 8'($urandom);
      rab = ($urandom % 2 == 0) ? 0 : int'($urandom_range(5, 2*H*(N+1)));
      ec  = 0;
      for (int k = 1; k <= N; k++)
        if (rab == 0 || 2*H*(k+1) + 1 <= rab) ec++;
      ed = rp >> (N - ec);
      run_xfer(rp, rab, got_d, got_c, got_dc, serr);
      check($sformatf("rnd%0d_data", r), got_d, ed);
      check($sformatf("rnd%0d_cnt", r), got_c, ec);
      check($sformatf("rnd%0d_done_cycle", r), got_dc, (rab == 0) ? 1 + 2*H*(N+1) : -1);
      check($sformatf("rnd%0d_waveform_errs", r), serr, 0);
    end

    // start held high: one done, then immediate restart
    pat = 8'h5A;
    fcnt = 0;
    got_dc = -1;
    serr = 0;
    start = 1'b1;
    cyc = 0;
    step();
    while (cyc < 39) begin
      if (done === 1'b1) begin
        if (got_dc < 0) got_dc = cyc;
        else serr++;
      end
      if (cyc == 38 && busy !== 1'b0) serr++;
      step();
    end
    check("held_done_cycle", got_dc, 37);
    check("held_restart_errs", serr, 0);
    check("held_sync_at_39", {busy, shr_syn}, 2'b11);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // reset mid-shift
    pat = 8'h96;
    fcnt = 0;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    while (cyc < 20) step();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {shr_clk, shr_syn, busy, done, bit_cnt, data_reg}, '0);
    repeat (3) begin
      step();
      check("midrst_held", {shr_clk, shr_syn, busy, done, bit_cnt, data_reg}, '0);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    serr = 0;
    repeat (40) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || shr_clk !== 1'b0) serr++;
    end
    check("midrst_after_release_errs", serr, 0);

    // start and abort together in idle
    start = 1'b1;
    abort = 1'b1;
    step();
    check("start_abort_idle", {busy, shr_syn, shr_clk}, 3'b000);
    step();
    check("start_abort_idle2", {busy, shr_syn, shr_clk}, 3'b000);
    start = 1'b0;
    abort = 1'b0;

    // full-width readback, alternating 1/0 starting with 1
    fcnt_b = 0;
    start_b = 1'b1;
    cyc = 0;
    step();
    start_b = 1'b0;
    found = -1;
    while (found < 0 && cyc < 4100) begin
      if (done_b === 1'b1) found = cyc;
      else step();
    end
    for (int i = 0; i < NB; i++) exp_big[NB-1-i] = (i % 2 == 0);
    check("big_done_cycle", found, 1 + 2*HB*(NB+1));
    check("big_cnt", bit_cnt_b, NB);
    check("big_msb", data_reg_b[NB-1], 1'b1);
    check("big_lsb", data_reg_b[0], 1'b1);
    check("big_data", data_reg_b, exp_big);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
